// File: rtl/tiny_dnn_mac_array.sv
// Multi-lane bfloat16 dot-product engine: per-lane weight RAM and accumulator share one broadcast
// activation stream; results are normalized (RNE) and serialized out over valid/ready.
module tiny_dnn_mac_array #(
    parameter int unsigned LANES = 8,
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10,
    parameter int unsigned ACC_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [AW-1:0]            len,
    input  logic                     bias_en,
    input  logic                     relu_en,
    output logic                     busy,
    input  logic                     d_valid,
    input  logic [15:0]              d,
    output logic                     d_ready,
    input  logic                     w_we,
    input  logic [$clog2(LANES)-1:0] w_lane,
    input  logic [AW-1:0]            w_addr,
    input  logic [15:0]              w_data,
    output logic                     o_valid,
    input  logic                     o_ready,
    output logic [$clog2(LANES)-1:0] o_lane,
    output logic [15:0]              o_data
);

    localparam int unsigned LW = $clog2(LANES);

    typedef enum logic [2:0] {StIdle, StRun, StBias, StDrain, StNorm, StOut} state_e;

    state_e                  state_q, state_d;
    logic [AW-1:0]           cnt_q, cnt_d, len_q, len_d;
    logic                    bias_en_q, bias_en_d, relu_en_q, relu_en_d;
    logic [LW-1:0]           lane_q, lane_d;
    logic                    s1_v_q, s1_v_d;
    logic [15:0]             s1_d_q, s1_d_d;
    logic signed [ACC_W-1:0] acc_man_q [LANES];
    logic signed [ACC_W-1:0] acc_man_d [LANES];
    logic signed [9:0]       acc_exp_q [LANES];
    logic signed [9:0]       acc_exp_d [LANES];
    logic [LANES-1:0]        lost_q, lost_d;
    logic [15:0]             res_q [LANES];
    logic [15:0]             res_d [LANES];
    logic [15:0]             wmem [LANES][DEPTH];
    logic [15:0]             rdata_q [LANES];
    logic [AW-1:0]           rd_addr;
    logic                    step_lost;

    // Product is aligned against the larger exponent so the accumulator is never shifted left.
    function automatic void acc_step(input logic [15:0] w, input logic [15:0] x,
                                     input logic signed [ACC_W-1:0] man_i,
                                     input logic signed [9:0] exp_i,
                                     output logic signed [ACC_W-1:0] man_o,
                                     output logic signed [9:0] exp_o, output logic lost_o);
        logic [15:0]             pm;
        logic signed [9:0]       pe;
        logic signed [ACC_W-1:0] pman;
        int                      sh;
        pm = {8'd0, 1'b1, w[6:0]} * {8'd0, 1'b1, x[6:0]};
        pe = $signed({2'b00, w[14:7]}) + $signed({2'b00, x[14:7]});
        pman = ACC_W'(pm);
        if (w[15] ^ x[15]) pman = -pman;
        sh = int'(pe) - int'(exp_i) + 16;
        man_o  = man_i;
        exp_o  = exp_i;
        lost_o = 1'b0;
        if (w[14:7] != 8'd0 && x[14:7] != 8'd0) begin
            if (man_i == '0) begin
                man_o = pman;
                exp_o = pe;
            end else if (sh < 0 || sh >= 64) begin
                lost_o = 1'b1;
            end else if (sh >= 16) begin
                man_o = (man_i >>> (sh - 16)) + pman;
                exp_o = pe;
            end else begin
                man_o = man_i + (pman >>> (16 - sh));
            end
        end
    endfunction

    // Value is man * 2^(e - 268); the biased result exponent is lead + e - 141.
    function automatic logic [15:0] normalize(input logic signed [ACC_W-1:0] man,
                                              input logic signed [9:0] e, input logic relu);
        logic [ACC_W-1:0] mag, n;
        logic [8:0]       r;
        logic             neg, up;
        logic [15:0]      res;
        int               p, be;
        neg = man[ACC_W-1];
        mag = neg ? $unsigned(-man) : $unsigned(man);
        p = 0;
        for (int i = 0; i < ACC_W; i++) if (mag[i]) p = i;
        n  = mag << (ACC_W - 1 - p);
        up = n[ACC_W-9] & ((|n[ACC_W-10:0]) | n[ACC_W-8]);
        r  = {2'b01, n[ACC_W-2 -: 7]} + {8'd0, up};
        be = p + int'(e) - 141 + int'(r[8]);
        if (mag == '0 || be <= 0)  res = 16'h0000;
        else if (be >= 255)        res = neg ? 16'hFF80 : 16'h7F80;
        else                       res = {neg, be[7:0], r[8] ? 7'd0 : r[6:0]};
        if (relu && neg) res = 16'h0000;
        return res;
    endfunction

    always_ff @(posedge clk) begin
        if (w_we && !busy) wmem[w_lane][w_addr] <= w_data;
        for (int l = 0; l < LANES; l++) rdata_q[l] <= wmem[l][rd_addr];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        bias_en_d = bias_en_q;
        relu_en_d = relu_en_q;
        lane_d    = lane_q;
        unique case (state_q)
            StIdle: if (start) begin
                len_d     = len;
                bias_en_d = bias_en;
                relu_en_d = relu_en;
                cnt_d     = '0;
                state_d   = (len == '0) ? StBias : StRun;
            end
            StRun: if (d_valid) begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q + AW'(1) == len_q) begin
                    cnt_d   = '0;
                    state_d = StBias;
                end
            end
            StBias: begin
                cnt_d   = '0;
                state_d = StDrain;
            end
            StDrain, StNorm: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == AW'(1)) begin
                    cnt_d   = '0;
                    state_d = (state_q == StDrain) ? StNorm : StOut;
                end
            end
            StOut: if (o_ready) begin
                if (lane_q == LW'(LANES - 1)) begin
                    lane_d  = '0;
                    state_d = StIdle;
                end else begin
                    lane_d = lane_q + LW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // The bias reuses the accumulate pipe as W[DEPTH-1] * 1.0.
    always_comb begin
        rd_addr = (state_q == StBias) ? AW'(DEPTH - 1) : cnt_q;
        s1_v_d  = (state_q == StRun && d_valid) || (state_q == StBias && bias_en_q);
        s1_d_d  = (state_q == StBias) ? 16'h3F80 : d;
    end

    always_comb begin
        lost_d    = lost_q;
        step_lost = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            acc_man_d[l] = acc_man_q[l];
            acc_exp_d[l] = acc_exp_q[l];
            res_d[l]     = res_q[l];
            if (s1_v_q) begin
                acc_step(rdata_q[l], s1_d_q, acc_man_q[l], acc_exp_q[l],
                         acc_man_d[l], acc_exp_d[l], step_lost);
                lost_d[l] = lost_q[l] | step_lost;
            end
            if (state_q == StIdle && start) begin
                acc_man_d[l] = '0;
                acc_exp_d[l] = '0;
                lost_d[l]    = 1'b0;
            end
            if (state_q == StNorm && cnt_q == AW'(1)) begin
                res_d[l] = normalize(acc_man_q[l], acc_exp_q[l], relu_en_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            len_q     <= '0;
            bias_en_q <= 1'b0;
            relu_en_q <= 1'b0;
            lane_q    <= '0;
            s1_v_q    <= 1'b0;
            s1_d_q    <= '0;
            lost_q    <= '0;
            for (int l = 0; l < LANES; l++) begin
                acc_man_q[l] <= '0;
                acc_exp_q[l] <= '0;
                res_q[l]     <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            bias_en_q <= bias_en_d;
            relu_en_q <= relu_en_d;
            lane_q    <= lane_d;
            s1_v_q    <= s1_v_d;
            s1_d_q    <= s1_d_d;
            lost_q    <= lost_d;
            for (int l = 0; l < LANES; l++) begin
                acc_man_q[l] <= acc_man_d[l];
                acc_exp_q[l] <= acc_exp_d[l];
                res_q[l]     <= res_d[l];
            end
        end
    end

    assign busy    = (state_q != StIdle);
    assign d_ready = (state_q == StRun);
    assign o_valid = (state_q == StOut);
    assign o_lane  = lane_q;
    assign o_data  = o_valid ? res_q[lane_q] : 16'h0000;

endmodule

// File: doc/tiny_dnn_mac_array.md
Name: tiny_dnn_mac_array

Overview:
- Parametrised successor of the single-lane bfloat16 MAC core: LANES independent weight memories and accumulators share one broadcast activation stream.
- A built-in sequencer runs one dot-product pass per `start`: accumulate LEN beats, add a per-lane bias, normalize with round-to-nearest-even, optionally apply ReLU.
- Lane results are serialized out as bfloat16 over a valid/ready port.
- Sits between the activation buffer and the layer output buffer in the MNIST accelerator.

Parameters:
- LANES, 8, number of parallel output channels.
- DEPTH, 1024, weight words per lane; address DEPTH-1 is reserved for the bias.
- AW, 10, address width; DEPTH <= 2**AW.
- ACC_W, 32, signed accumulator mantissa width.

Ports:
- clk  in  1  clock, all flops on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; begins a pass when IDLE, ignored otherwise.
- len  in  AW  beat count for the pass, sampled on start; 0 means bias-only.
- bias_en  in  1  sampled on start; 1 adds W[lane][DEPTH-1].
- relu_en  in  1  sampled on start; 1 clamps negative results to 0x0000.
- busy  out  1  high from accepted start until the last lane result is taken.
- d_valid  in  1  activation beat valid.
- d  in  16  bfloat16 activation.
- d_ready  out  1  high only in RUN while beats remain.
- w_we  in  1  weight write strobe; honoured only when busy=0.
- w_lane  in  $clog2(LANES)  lane select.
- w_addr  in  AW  word address.
- w_data  in  16  bfloat16 weight.
- o_valid  out  1  lane result valid.
- o_ready  in  1  downstream accept.
- o_lane  out  $clog2(LANES)  lane index of o_data.
- o_data  out  16  bfloat16 result.

Behaviour:
- Reset values: busy=0, d_ready=0, o_valid=0, o_lane=0, o_data=0, FSM=IDLE, accumulators cleared. Weight RAM is not reset.
- Reset asserted mid-pass aborts the pass immediately; no partial output is produced.
- FSM states: IDLE -> RUN (start) -> BIAS -> DRAIN -> NORM -> OUT -> IDLE.
  - RUN counts accepted beats (d_valid & d_ready); after beat len it moves to BIAS. len=0 skips RUN.
  - BIAS is 1 cycle: if bias_en, inject product W[DEPTH-1]*1.0 (0x3F80) in all lanes; else nothing.
  - DRAIN holds 2 cycles to empty the pipe.
  - NORM takes 2 cycles, all lanes in parallel; results go to a LANES-entry output register.
  - OUT presents lanes 0..LANES-1 in order; each advances on o_valid&o_ready; o_valid/o_data hold while o_ready=0. IDLE after lane LANES-1 is taken.
- Accumulate pipeline: beat accepted at cycle t -> weight read t+1 -> product, align and add t+2. Running address resets to 0 on start.
- Product arithmetic:
  - mantissa = {1,w[6:0]}*{1,d[6:0]}, 16 bits exact.
  - exponent = w[14:7]+d[14:7]; sign = w^d.
  - Exponent field 0 on either operand gives product zero (denormals flushed). Inf/NaN unsupported, treated as finite.
- Accumulator per lane is {sign, 10b signed exp, ACC_W signed mantissa}, aligned as the existing fma:
  - shift = exp_p - acc_exp + 16.
  - shift < 0 or >= 64: product dropped, sticky lane flag `lost` set (internal, visible to bench).
  - Otherwise the accumulator is realigned to the product exponent and added.
- Normalize: leading-one detect over ACC_W, then RNE to 7-bit fraction.
  - Mantissa 0 gives 0x0000.
  - Biased exponent <= 0 gives 0x0000.
  - Biased exponent >= 255, including after rounding carry, gives ±Inf (0x7F80/0xFF80).
  - ReLU applies after rounding; -0 is output as 0x0000.
- Simultaneous events:
  - start while busy is ignored.
  - w_we while busy is dropped; no error port.
  - w_we and start in the same cycle in IDLE: the write completes first and is visible to the pass.
  - o_ready held high gives one lane per cycle.

Test Plan:
- All lanes W[0..3]=0x3F80; start len=4, bias_en=0; d=0x4000 x4 -> each lane o_data=0x4100 (8.0); o_lane 0..7 in order.
- As above plus W[DEPTH-1]=0x3F00, bias_en=1 -> o_data=0x4108 (8.5).
- Lane 3 weights 0xBF80, relu_en=0 -> lane 3 o_data=0xC100; repeat with relu_en=1 -> 0x0000, other lanes unchanged.
- RNE: W=[0x3F80,0x3B80], d=0x3F80 x2 -> 0x3F80 (tie to even); W=[0x3F80,0x3C40] -> 0x3F82.
- Backpressure and gaps: d_valid toggled 50%, o_ready low 3 cycles per lane -> identical results, o_data stable while stalled, busy falls after the last accept.
- Reset pulse mid-RUN, then new pass len=0 with bias_en=1 and bias 0x4040 -> all lanes 0x4040; start and w_we while busy have no effect.
